gravity_timer: RTL and testbench
================================

# gravity_timer

Consumer end of the 0.1 s tick interface: takes the one-cycle `tick` pulse from the 0.1 s clock divisor and turns it into piece-drop requests for the Tetris game FSM. It counts ticks against a level-dependent drop interval, raises a held `drop_req`, and keeps it high until the game FSM acknowledges it. It also supports pause, soft-drop and per-piece restart, and keeps drop and overrun statistics.

## Interface
- `BASE_TICKS`, default 10: ticks per drop at level 0 (1.0 s).
- `STEP_TICKS`, default 1: ticks removed per level.
- `MIN_TICKS`, default 1: floor of the interval; a value of 0 is treated as 1.
- `SOFT_TICKS`, default 1: interval while `soft_drop` is high.
- `CNT_W`, default 8: width of the tick counter and the interval.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset. It has highest priority.
- `tick`, in, 1: one-cycle pulse from the 0.1 s divisor.
- `level`, in, 4: game level, 0–15.
- `soft_drop`, in, 1: level signal; selects `SOFT_TICKS`.
- `pause`, in, 1: level signal; while high, ticks are ignored.
- `restart`, in, 1: one-cycle pulse when a new piece spawns.
- `drop_ack`, in, 1: game FSM has consumed the request.
- `drop_req`, out, 1: registered drop request.
- `tick_cnt`, out, CNT_W: current tick count.
- `drop_count`, out, 16: accepted drops; wraps from 65535 to 0.
- `overrun_cnt`, out, 8: saturating count of intervals that expired while a request was pending.

## Operation
- Effective interval `ivl`, combinational:
  - if `soft_drop` is high: `SOFT_TICKS`;
  - otherwise: max(`MIN_TICKS`, `BASE_TICKS` − `level`·`STEP_TICKS`).
  - The subtraction is done at CNT_W+5 bits and saturates at the floor; it never wraps.
- A counted tick is a cycle with `tick`=1 and `pause`=0.
- State RUN (`drop_req`=0):
  - On a counted tick with `tick_cnt`+1 ≥ `ivl`: set `tick_cnt` to 0, set `drop_req` to 1, go to WAIT.
  - On a counted tick otherwise: increment `tick_cnt`.
- State WAIT (`drop_req`=1):
  - When `drop_ack`=1: clear `drop_req`, increment `drop_count`, go to RUN. `tick_cnt` is not reset.
  - Counted ticks in WAIT are handled as described under Configuration.
- `drop_ack` in RUN is ignored.
- A change to `level` or `soft_drop` takes effect at the next counted tick. If `tick_cnt` is already ≥ the new `ivl`, the next counted tick fires.
- `restart`: set `tick_cnt` to 0, clear `drop_req`, go to RUN.
  - Overrides any tick or ack in the same cycle. The tick is lost and `drop_count` is not incremented.
  - `overrun_cnt` is not cleared.
- `pause`: freezes `tick_cnt`. It does not block the `drop_req`/`drop_ack` handshake.

## Timing
- Reset values: `drop_req`=0, `tick_cnt`=0, `drop_count`=0, `overrun_cnt`=0, state RUN. All outputs show these values on the cycle after `rst` is sampled high, including when reset arrives mid-WAIT.
- Latency:
  - `drop_req` rises on the clock edge that samples the firing tick; it is visible the next cycle.
  - `drop_req` falls on the edge that samples `drop_ack`=1; `drop_count` updates on the same edge.
- If `drop_ack` is held high in RUN, `drop_req` is high for exactly one cycle.
- Priority when events coincide: `rst` > `restart` > ack/tick.
- In WAIT, an ack and a tick in the same cycle are both processed: the ack completes, and the tick is counted only if the macro is defined.
- `tick` pulses are assumed to be at least 2 cycles apart. Back-to-back ticks are still each counted.

## Configuration
- `GRAVITY_OVERRUN_EN` defined:
  - Counted ticks in WAIT increment `tick_cnt`.
  - On reaching `ivl`, `tick_cnt` goes to 0 and `overrun_cnt` increments, saturating at 255.
  - `drop_req` stays at 1.
- `GRAVITY_OVERRUN_EN` not defined:
  - Ticks in WAIT are ignored; `tick_cnt` holds.
  - `overrun_cnt` is tied to 0 and no counter logic is synthesized.

## Test plan
- Defaults, `level`=0, `drop_ack` tied to 1: `drop_req` pulses for one cycle after tick 10, 20 and 30; `drop_count`=3 after 30 ticks.
- `level`=12: `ivl` clamps to 1 and the design fires after every tick. Then `soft_drop`=1 at `level`=0: fires every tick. Release `soft_drop` with `tick_cnt`=0: next fire after 10 ticks.
- `level`=0, `drop_ack` held at 0, 30 ticks:
  - macro defined: `drop_req`=1, `overrun_cnt`=2, `tick_cnt`=0;
  - macro undefined: `overrun_cnt`=0, `tick_cnt`=0.
  - Then one `drop_ack`: `drop_count`=1 and `drop_req` is 0 on the next cycle.
- `tick_cnt`=9 at `level`=0, with `restart` and `tick` in the same cycle: `tick_cnt`=0, `drop_req` stays 0, and 10 more ticks are needed to fire.
- `pause`=1 with `tick_cnt`=5 for 20 ticks: `tick_cnt` stays 5 and no request is made. A request already pending before `pause` is still cleared by `drop_ack` and increments `drop_count`.
- Assert `rst` for one cycle while in WAIT with non-zero counters: all outputs are 0 on the next cycle, and 10 ticks are needed for the next request.

Source files
------------

// File: rtl/gravity_timer_if.sv
// Tick/drop handshake bundle between the gravity timer and the Tetris game FSM.
interface gravity_timer_if #(
  parameter int CNT_W = 8
);
  logic             tick;
  logic [3:0]       level;
  logic             soft_drop;
  logic             pause;
  logic             restart;
  logic             drop_ack;
  logic             drop_req;
  logic [CNT_W-1:0] tick_cnt;
  logic [15:0]      drop_count;
  logic [7:0]       overrun_cnt;

  modport master (
    output tick, level, soft_drop, pause, restart, drop_ack,
    input  drop_req, tick_cnt, drop_count, overrun_cnt
  );

  modport slave (
    input  tick, level, soft_drop, pause, restart, drop_ack,
    output drop_req, tick_cnt, drop_count, overrun_cnt
  );
endinterface

// File: rtl/gravity_timer.sv
// Turns 0.1 s ticks into held, acknowledged piece-drop requests with level-dependent interval.
// Optional macro GRAVITY_OVERRUN_EN: keep counting in WAIT and count expired intervals.
module gravity_timer #(
  parameter int BASE_TICKS = 10,
  parameter int STEP_TICKS = 1,
  parameter int MIN_TICKS  = 1,
  parameter int SOFT_TICKS = 1,
  parameter int CNT_W      = 8
) (
  input  logic           clk,
  input  logic           rst,
  gravity_timer_if.slave bus
);
  localparam int IW = CNT_W + 5;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_tick_cnt, w_tick_cnt_next;
  logic [15:0]      r_drop_count, w_drop_count_next;

  logic [IW-1:0] w_base, w_dec, w_floor, w_diff, w_hard, w_ivl, w_cnt_inc;
  logic          w_counted, w_expire;

  // Interval math is done wide so a large level never wraps below the floor.
  assign w_base    = IW'(BASE_TICKS);
  assign w_dec     = IW'(bus.level) * IW'(STEP_TICKS);
  assign w_floor   = (MIN_TICKS == 0) ? IW'(1) : IW'(MIN_TICKS);
  assign w_diff    = (w_base > w_dec) ? (w_base - w_dec) : '0;
  assign w_hard    = (w_diff > w_floor) ? w_diff : w_floor;
  assign w_ivl     = bus.soft_drop ? IW'(SOFT_TICKS) : w_hard;
  assign w_cnt_inc = IW'(r_tick_cnt) + IW'(1);
  assign w_expire  = (w_cnt_inc >= w_ivl);
  assign w_counted = bus.tick & ~bus.pause;

`ifdef GRAVITY_OVERRUN_EN
  logic [7:0] r_overrun_cnt, w_overrun_cnt_next;
`endif

  always_comb begin
    w_state_next      = r_state;
    w_tick_cnt_next   = r_tick_cnt;
    w_drop_count_next = r_drop_count;
`ifdef GRAVITY_OVERRUN_EN
    w_overrun_cnt_next = r_overrun_cnt;
`endif
    if (bus.restart) begin
      w_state_next    = ST_RUN;
      w_tick_cnt_next = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_counted) begin
            if (w_expire) begin
              w_tick_cnt_next = '0;
              w_state_next    = ST_WAIT;
            end else begin
              w_tick_cnt_next = r_tick_cnt + 1'b1;
            end
          end
        end
        ST_WAIT: begin
`ifdef GRAVITY_OVERRUN_EN
          if (w_counted) begin
            if (w_expire) begin
              w_tick_cnt_next = '0;
              if (r_overrun_cnt != 8'hFF)
                w_overrun_cnt_next = r_overrun_cnt + 8'd1;
            end else begin
              w_tick_cnt_next = r_tick_cnt + 1'b1;
            end
          end
`endif
          if (bus.drop_ack) begin
            w_state_next      = ST_RUN;
            w_drop_count_next = r_drop_count + 16'd1;
          end
        end
        default: w_state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_tick_cnt   <= '0;
      r_drop_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_tick_cnt   <= w_tick_cnt_next;
      r_drop_count <= w_drop_count_next;
    end
  end

`ifdef GRAVITY_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_overrun_cnt <= '0;
    else
      r_overrun_cnt <= w_overrun_cnt_next;
  end
  assign bus.overrun_cnt = r_overrun_cnt;
`else
  assign bus.overrun_cnt = '0;
`endif

  assign bus.drop_req   = (r_state == ST_WAIT);
  assign bus.tick_cnt   = r_tick_cnt;
  assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_gravity_timer.sv
// Directed self-checking bench for gravity_timer; outputs sampled on the falling edge.
module tb_gravity_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef GRAVITY_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  gravity_timer_if #(.CNT_W(8)) bus ();

  gravity_timer #(
    .BASE_TICKS(10),
    .STEP_TICKS(1),
    .MIN_TICKS (1),
    .SOFT_TICKS(1),
    .CNT_W     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick(input logic with_restart);
    @(negedge clk);
    bus.tick    = 1'b1;
    bus.restart = with_restart;
    @(negedge clk);
    bus.tick    = 1'b0;
    bus.restart = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus.drop_ack = 1'b1;
    @(negedge clk);
    bus.drop_ack = 1'b0;
  endtask

  initial begin
    bus.tick      = 1'b0;
    bus.level     = 4'd0;
    bus.soft_drop = 1'b0;
    bus.pause     = 1'b0;
    bus.restart   = 1'b0;
    bus.drop_ack  = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst_req",   bus.drop_req,    0);
    check("rst_cnt",   bus.tick_cnt,    0);
    check("rst_drops", bus.drop_count,  0);
    check("rst_ovr",   bus.overrun_cnt, 0);

    // Level 0, ack tied high: one-cycle request every 10 ticks.
    for (int i = 0; i < 30; i++) begin
      do_tick(1'b0);
      check($sformatf("l0_req_t%0d", i + 1), bus.drop_req, (i % 10 == 9) ? 1 : 0);
      if (i % 10 == 9) begin
        idle(1);
        check($sformatf("l0_pulse_end_t%0d", i + 1), bus.drop_req, 0);
      end
    end
    check("l0_drops", bus.drop_count, 3);
    check("l0_cnt",   bus.tick_cnt,   0);

    // Level 12 clamps to the floor of 1.
    bus.level = 4'd12;
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b0);
      check("l12_req", bus.drop_req, 1);
      idle(1);
      check("l12_clr", bus.drop_req, 0);
    end
    bus.level     = 4'd0;
    bus.soft_drop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b0);
      check("soft_req", bus.drop_req, 1);
      idle(1);
      check("soft_clr", bus.drop_req, 0);
    end
    bus.soft_drop = 1'b0;
    check("soft_rel_cnt", bus.tick_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      do_tick(1'b0);
      if (i == 8 || i == 9)
        check($sformatf("soft_rel_req_t%0d", i + 1), bus.drop_req, (i == 9) ? 1 : 0);
    end
    idle(1);
    check("soft_rel_drops", bus.drop_count, 10);

    // Ack held low for 30 ticks: pending request, overruns when enabled.
    bus.drop_ack = 1'b0;
    do_reset();
    ticks(30);
    check("ovr_req",   bus.drop_req,    1);
    check("ovr_cnt",   bus.overrun_cnt, OVR_EN ? 2 : 0);
    check("ovr_tcnt",  bus.tick_cnt,    0);
    check("ovr_drops", bus.drop_count,  0);
    ack_pulse();
    check("ovr_ack_req",   bus.drop_req,    0);
    check("ovr_ack_drops", bus.drop_count,  1);
    check("ovr_ack_keep",  bus.overrun_cnt, OVR_EN ? 2 : 0);

    // Restart coincident with the tick that would have fired.
    bus.drop_ack = 1'b1;
    do_reset();
    ticks(9);
    check("rs_pre_cnt", bus.tick_cnt, 9);
    do_tick(1'b1);
    check("rs_cnt",   bus.tick_cnt,   0);
    check("rs_req",   bus.drop_req,   0);
    check("rs_drops", bus.drop_count, 0);
    ticks(9);
    check("rs_9_req", bus.drop_req, 0);
    check("rs_9_cnt", bus.tick_cnt, 9);
    do_tick(1'b0);
    check("rs_10_req", bus.drop_req, 1);
    idle(1);

    // Pause freezes counting but not the handshake.
    do_reset();
    ticks(5);
    check("pz_pre_cnt", bus.tick_cnt, 5);
    bus.pause = 1'b1;
    ticks(20);
    check("pz_cnt", bus.tick_cnt, 5);
    check("pz_req", bus.drop_req, 0);
    bus.pause    = 1'b0;
    bus.drop_ack = 1'b0;
    ticks(5);
    check("pz_fire_req", bus.drop_req, 1);
    bus.pause = 1'b1;
    ack_pulse();
    check("pz_ack_req",   bus.drop_req,   0);
    check("pz_ack_drops", bus.drop_count, 1);
    bus.pause = 1'b0;

    // Reset in WAIT with non-zero counters.
    ticks(15);
    check("rw_pre_req", bus.drop_req, 1);
    check("rw_pre_cnt", bus.tick_cnt, OVR_EN ? 5 : 0);
    do_reset();
    check("rw_req",   bus.drop_req,    0);
    check("rw_cnt",   bus.tick_cnt,    0);
    check("rw_drops", bus.drop_count,  0);
    check("rw_ovr",   bus.overrun_cnt, 0);
    bus.drop_ack = 1'b1;
    ticks(9);
    check("rw_9_req", bus.drop_req, 0);
    do_tick(1'b0);
    check("rw_10_req", bus.drop_req, 1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
